mcoi_ps_buffer_mux: RTL

//  Parametrised multi-channel writer into the PS shared-memory (BRAM) port.
//  NCH application producers stream frames; a round-robin arbiter writes one word/cycle into a
//  per-channel region of shared memory and raises a per-channel doorbell on frame end.
//  The PS acknowledges through the shared control register.

---
 rtl/mcoi_ps_buffer_mux.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mcoi_ps_buffer_mux.sv
// Multi-channel frame writer into the PS shared-memory port: round-robin arbitration,
// per-channel regions, doorbell/overflow/frame-count status and PS acknowledge handling.
module mcoi_ps_buffer_mux #(
  parameter int NCH      = 4,
  parameter int DATA_W   = 32,
  parameter int REGION_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        wr_valid,
  output logic [NCH-1:0]        wr_ready,
  input  logic [NCH*DATA_W-1:0] wr_data,
  input  logic [NCH-1:0]        wr_last,
  input  logic [31:0]           ctrl,
  output logic [31:0]           status,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_W-1:0]     mem_din
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [REGION_W:0] REGION_WORDS = {1'b1, {REGION_W{1'b0}}};

  logic [CW-1:0]     rr_q, rr_d;
  logic [REGION_W:0] ptr_q [NCH];
  logic [REGION_W:0] ptr_d [NCH];
  logic [NCH-1:0]    db_q, db_d;
  logic [NCH-1:0]    ov_q, ov_d;
  logic [NCH-1:0]    ctrl_prev_q, ctrl_prev_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [31:0]       status_q, status_d;

  logic [NCH-1:0]    elig;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    ack;
  logic              gnt_any;
  logic [CW-1:0]     gnt_idx;
  logic [CW:0]       cand;
  logic [DATA_W-1:0] word_sel;
  logic              last_sel;
  logic [REGION_W:0] ptr_sel;

  // Only the channel-enable and ack fields of ctrl carry meaning here.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl;

  // Arbiter: search eligible channels starting one past the last grant.
  always_comb begin
    elig    = ctrl[8 +: NCH] & ~db_q & wr_valid;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    cand    = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = {1'b0, rr_q} + (CW+1)'(i);
      if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
      if (!gnt_any && reset_n && elig[cand[CW-1:0]]) begin
        gnt_any              = 1'b1;
        gnt_idx              = cand[CW-1:0];
        grant[cand[CW-1:0]]  = 1'b1;
      end
    end
  end

  assign ack = ctrl[NCH-1:0] & ~ctrl_prev_q & db_q;

  always_comb begin
    word_sel = '0;
    last_sel = 1'b0;
    ptr_sel  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant[c]) begin
        word_sel = wr_data[c*DATA_W +: DATA_W];
        last_sel = wr_last[c];
        ptr_sel  = ptr_q[c];
      end
    end
  end

  // Acks act on the doorbell as it stood before this cycle; a granted channel
  // never has its doorbell set, so the two updates cannot collide.
  always_comb begin
    rr_d        = rr_q;
    db_d        = db_q & ~ack;
    ov_d        = ov_q & ~ack;
    fcnt_d      = fcnt_q;
    ctrl_prev_d = ctrl[NCH-1:0];
    for (int c = 0; c < NCH; c++) begin
      ptr_d[c] = ack[c] ? '0 : ptr_q[c];
    end
    mem_en_d   = 1'b0;
    mem_we_d   = 4'h0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (gnt_any) begin
      rr_d = gnt_idx;
      if (ptr_sel < REGION_WORDS) begin
        mem_en_d   = 1'b1;
        mem_we_d   = 4'hF;
        mem_addr_d = 32'({gnt_idx, ptr_sel[REGION_W-1:0], 2'b00});
        mem_din_d  = word_sel;
        for (int c = 0; c < NCH; c++) begin
          if (grant[c]) ptr_d[c] = ptr_q[c] + (REGION_W+1)'(1);
        end
      end else begin
        ov_d = ov_d | grant;
      end
      if (last_sel) begin
        db_d   = db_d | grant;
        fcnt_d = fcnt_q + 16'd1;
      end
    end
    status_d = {fcnt_d, 8'(ov_d), 8'(db_d)};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q        <= '0;
      db_q        <= '0;
      ov_q        <= '0;
      ctrl_prev_q <= '0;
      fcnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      status_q    <= '0;
      for (int c = 0; c < NCH; c++) ptr_q[c] <= '0;
    end else begin
      rr_q        <= rr_d;
      db_q        <= db_d;
      ov_q        <= ov_d;
      ctrl_prev_q <= ctrl_prev_d;
      fcnt_q      <= fcnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      status_q    <= status_d;
      for (int c = 0; c < NCH; c++) ptr_q[c] <= ptr_d[c];
    end
  end

  assign wr_ready = grant;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign status   = status_q;

endmodule
